// File: rtl/sw_led_pkg.sv
// Shared types and constants for the switch/button-to-LED sequencer.
package sw_led_pkg;

  typedef enum logic [2:0] {
    PASS    = 3'd0,
    XOR     = 3'd1,
    ALLONES = 3'd2,
    SHIFT   = 3'd3,
    CLEAR   = 3'd4
  } mode_t;

  localparam int unsigned SW_LED_WIDTH        = 16;
  localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/button_debounce.sv
// Per-button 2-FF synchroniser, counter debouncer and rising-edge press pulse.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic press_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The level flips after DEBOUNCE_CYCLES consecutive differing samples; only 0->1 pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      cnt         <= '0;
      level_out   <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= raw_in;
      sync2       <= sync1;
      press_pulse <= 1'b0;
      if (sync2 == level_out) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt         <= '0;
        level_out   <= sync2;
        press_pulse <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sw_led_op_seq.sv
// Switch/button-to-LED sequencer: sticky button-selected modes drive a registered LED stage.
// Define SW_LED_OP_ROTATE_EN to make SHIFT mode a left rotate instead of a zero-fill shift.
module sw_led_op_seq
  import sw_led_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_LED_WIDTH,
  parameter int unsigned SHIFT_AMT       = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btnu,
  input  logic             btnd,
  input  logic             btnl,
  input  logic             btnr,
  output logic [WIDTH-1:0] led,
  output logic [2:0]       mode
);

  localparam int unsigned HW = WIDTH / 2;

  logic [WIDTH-1:0] sw_m;
  logic [WIDTH-1:0] sw_s;
  logic [3:0]       raw_btn;
  logic [3:0]       lvl;
  logic [3:0]       pls;
  logic [3:0]       press;
  mode_t            mode_q;
  mode_t            target;
  logic             any_press;
  logic [WIDTH-1:0] led_d;

  // Bit order l, r, d, u: index 0 has the highest priority.
  assign raw_btn = {btnu, btnd, btnr, btnl};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk        (clk),
      .reset      (reset),
      .raw_in     (raw_btn[i]),
      .level_out  (lvl[i]),
      .press_pulse(pls[i])
    );
  end

  assign press = pls & lvl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= sw;
      sw_s <= sw_m;
    end
  end

  always_comb begin
    target    = PASS;
    any_press = |press;
    if (press[0])      target = XOR;
    else if (press[1]) target = ALLONES;
    else if (press[2]) target = SHIFT;
    else if (press[3]) target = CLEAR;
  end

  // Mode register; pressing the button of the current mode toggles back to PASS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= PASS;
    end else begin
      case (mode_q)
        PASS, XOR, ALLONES, SHIFT, CLEAR: begin
          if (any_press) mode_q <= (target == mode_q) ? PASS : target;
        end
        default: mode_q <= PASS;
      endcase
    end
  end

  assign mode = mode_q;

  always_comb begin
    led_d = '0;
    case (mode_q)
      PASS:    led_d = sw_s;
      XOR:     led_d = {{HW{1'b0}}, sw_s[WIDTH-1:HW] ^ sw_s[HW-1:0]};
      ALLONES: led_d = {{(WIDTH-1){1'b0}}, &sw_s};
`ifdef SW_LED_OP_ROTATE_EN
      SHIFT:   led_d = (sw_s << SHIFT_AMT) | (sw_s >> (WIDTH - SHIFT_AMT));
`else
      SHIFT:   led_d = sw_s << SHIFT_AMT;
`endif
      CLEAR:   led_d = '0;
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) led <= '0;
    else       led <= led_d;
  end

endmodule

// File: tb/tb_sw_led_op_seq.sv
// Self-checking bench: directed plan checks plus randomized stimulus against a history-window model.
module tb_sw_led_op_seq;
  import sw_led_pkg::*;

  localparam int W = 16;
  localparam int S = 3;
  localparam int D = SIM_DEBOUNCE_CYCLES;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sw = '0;
  logic         btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0;
  logic [W-1:0] led;
  logic [2:0]   mode;

  int n_tests = 0;
  int n_fail  = 0;

  sw_led_op_seq #(.WIDTH(W), .SHIFT_AMT(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .sw(sw), .btnu(btnu), .btnd(btnd),
    .btnl(btnl), .btnr(btnr), .led(led), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: raw-sample history windows and plain mode/output rules.
  logic [D:0]   bh [4];
  logic         m_lvl [4];
  logic         m_pulse [4];
  logic [W-1:0] swh0 = '0, swh1 = '0;
  int           m_mode = 0;
  logic [W-1:0] m_led = '0;

  function automatic logic [W-1:0] led_of(input int md, input logic [W-1:0] x);
    logic [W-1:0] r;
    r = '0;
    case (md)
      0: r = x;
      1: for (int i = 0; i < W/2; i++) r[i] = x[i] ^ x[i + W/2];
      2: r[0] = (x == {W{1'b1}});
      3: for (int i = 0; i < W; i++) begin
`ifdef SW_LED_OP_ROTATE_EN
           r[(i + S) % W] = x[i];
`else
           if (i + S < W) r[i + S] = x[i];
`endif
         end
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic raw [4];
    logic nl;
    int   tgt;
    if (reset) begin
      for (int b = 0; b < 4; b++) begin
        bh[b] = '0; m_lvl[b] = 1'b0; m_pulse[b] = 1'b0;
      end
      swh0 = '0; swh1 = '0; m_mode = 0; m_led = '0;
    end else begin
      raw[0] = btnl; raw[1] = btnr; raw[2] = btnd; raw[3] = btnu;
      m_led = led_of(m_mode, swh1);
      tgt = 0;
      for (int b = 3; b >= 0; b--) if (m_pulse[b]) tgt = b + 1;
      if (tgt != 0) m_mode = (m_mode == tgt) ? 0 : tgt;
      for (int b = 0; b < 4; b++) begin
        nl = m_lvl[b];
        if (!m_lvl[b] && bh[b][D:1] == {D{1'b1}}) nl = 1'b1;
        if (m_lvl[b] && bh[b][D:1] == {D{1'b0}}) nl = 1'b0;
        m_pulse[b] = nl & ~m_lvl[b];
        m_lvl[b] = nl;
        bh[b] = {bh[b][D-1:0], raw[b]};
      end
      swh1 = swh0;
      swh0 = sw;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("model_led", 32'(led), 32'(m_led));
      check("model_mode", 32'(mode), 32'(m_mode));
    end
  end

  task automatic mid_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_led"}, 32'(led), 32'h0);
    check({tag, "_mode"}, 32'(mode), 32'h0);
    @(negedge clk) reset = 1'b0;
  endtask

  initial begin
    tick(3);
    check("rst_led", 32'(led), 32'h0);
    check("rst_mode", 32'(mode), 32'h0);
    reset = 1'b0;

    sw = 16'hA5C3; tick(2);
    check("sw_lat2", 32'(led), 32'h0);
    tick(1);
    check("sw_lat3", 32'(led), 32'hA5C3);
    check("pass_mode", 32'(mode), 32'd0);

    btnl = 1'b1; tick(6);
    check("l_early", 32'(mode), 32'd0);
    tick(1);
    check("l_mode", 32'(mode), 32'd1);
    sw = 16'hF00F; tick(3);
    check("xor_led", 32'(led), 32'h00FF);
    btnl = 1'b0; tick(8);
    btnl = 1'b1; tick(7);
    check("l_toggle", 32'(mode), 32'd0);
    tick(1);
    check("toggle_led", 32'(led), 32'hF00F);
    btnl = 1'b0; tick(8);

    btnr = 1'b1; sw = 16'hFFFF; tick(7);
    check("r_mode", 32'(mode), 32'd2);
    tick(1);
    check("and_ones", 32'(led), 32'h0001);
    sw = 16'hFFFE; tick(3);
    check("and_zero", 32'(led), 32'h0000);
    btnr = 1'b0; tick(8);

    btnd = 1'b1; sw = 16'hE001; tick(7);
    check("d_mode", 32'(mode), 32'd3);
    tick(1);
`ifdef SW_LED_OP_ROTATE_EN
    check("shift_led", 32'(led), 32'h000F);
`else
    check("shift_led", 32'(led), 32'h0008);
`endif
    btnd = 1'b0; tick(8);

    for (int i = 0; i < 10; i++) begin
      btnu = ~btnu; tick(2);
    end
    check("bounce_mode", 32'(mode), 32'd3);
    btnu = 1'b1; tick(6);
    check("u_early", 32'(mode), 32'd3);
    tick(1);
    check("u_mode", 32'(mode), 32'd4);
    tick(1);
    check("clear_led", 32'(led), 32'h0);
    btnu = 1'b0; tick(8);

    btnl = 1'b1; btnu = 1'b1; tick(7);
    check("prio_mode", 32'(mode), 32'd1);
    tick(2);
    mid_reset("midrst");
    tick(6);
    check("rehold_early", 32'(mode), 32'd0);
    tick(1);
    check("rehold_mode", 32'(mode), 32'd1);
    btnl = 1'b0; btnu = 1'b0; tick(8);

    repeat (250) begin
      sw = W'($urandom);
      if ($urandom_range(0, 2) == 0) btnl = ~btnl;
      if ($urandom_range(0, 2) == 0) btnr = ~btnr;
      if ($urandom_range(0, 2) == 0) btnd = ~btnd;
      if ($urandom_range(0, 2) == 0) btnu = ~btnu;
      tick($urandom_range(1, 10));
      if ($urandom_range(0, 49) == 0) mid_reset("rnd_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
